// File: rtl/pc_gen_pkg.sv
// Shared types and defaults for the fetch-stage program-counter generator.
package pc_gen_pkg;

  localparam int          XLEN_DEF         = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TVEC_RESET_DEF   = 32'h0000_0100;
  localparam int          ALIGN_BITS_DEF   = 2;
  localparam int          INC_DEF          = 4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Which source won the next-PC arbitration this cycle.
  typedef enum logic [2:0] {
    SRC_TRAP = 3'd0,
    SRC_MRET = 3'd1,
    SRC_BR   = 3'd2,
    SRC_SEQ  = 3'd3,
    SRC_HOLD = 3'd4
  } src_t;

  // True for the flush-type sources that override stall and pending fetches.
  function automatic logic is_redirect(input src_t src);
    return (src == SRC_TRAP) || (src == SRC_MRET) || (src == SRC_BR);
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch request bus between the PC generator and instruction memory.
interface pc_gen_if
  import pc_gen_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);

  logic            imem_req_o;
  logic            imem_ready_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc_plus_o;

  modport master (
    output imem_req_o,
    output pc_o,
    output pc_plus_o,
    input  imem_ready_i
  );

  modport slave (
    input  imem_req_o,
    input  pc_o,
    input  pc_plus_o,
    output imem_ready_i
  );

endinterface

// File: rtl/pc_gen_next_sel.sv
// Combinational next-PC priority mux: trap > mret > branch > sequential > hold.
// A misaligned branch target is folded into the trap path.
module pc_next_sel
  import pc_gen_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int ALIGN_BITS = ALIGN_BITS_DEF
) (
  input  logic            run_st,
  input  logic            halt_st,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            mret_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            seq_fire,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus,
  input  logic [XLEN-1:0] epc,
  input  logic [XLEN-1:0] tvec,
  output logic [XLEN-1:0] pc_next,
  output src_t            src,
  output logic            epc_load,
  output logic [XLEN-1:0] epc_next,
  output logic            misalign_next
);

  // Mask form keeps ALIGN_BITS == 0 legal (no zero-width slice).
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

  logic            active;
  logic            br_misaligned;
  logic [XLEN-1:0] tvec_aligned;

  assign active        = run_st || halt_st;
  assign br_misaligned = |(redirect_pc_i & ALIGN_MASK);
  assign tvec_aligned  = tvec & ~ALIGN_MASK;

  // Priority selection of the next PC and the exception-PC update.
  always_comb begin
    pc_next       = pc;
    src           = SRC_HOLD;
    epc_load      = 1'b0;
    epc_next      = epc;
    misalign_next = 1'b0;
    if (active && trap_i) begin
      src      = SRC_TRAP;
      pc_next  = tvec_aligned;
      epc_load = 1'b1;
      epc_next = trap_pc_i;
    end else if (run_st && mret_i) begin
      src     = SRC_MRET;
      pc_next = epc;
    end else if (active && redirect_valid_i) begin
      if (br_misaligned) begin
        src           = SRC_TRAP;
        pc_next       = tvec_aligned;
        epc_load      = 1'b1;
        epc_next      = redirect_pc_i;
        misalign_next = 1'b1;
      end else begin
        src     = SRC_BR;
        pc_next = redirect_pc_i;
      end
    end else if (run_st && seq_fire) begin
      src     = SRC_SEQ;
      pc_next = pc_plus;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator with trap/mret/branch redirects,
// trap-vector and exception-PC registers, WFI halt and a req/ready fetch bus.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_BOOT | first cycle after reset, no fetch request, pc held
// ST_RUN  | fetching: req=1, pc advances on accepted un-stalled fetch
// ST_HALT | WFI: req=0, pc held, woken only by trap or branch redirect
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter logic [XLEN-1:0] TVEC_RESET   = XLEN'(TVEC_RESET_DEF),
  parameter int              ALIGN_BITS   = ALIGN_BITS_DEF,
  parameter int              INC          = INC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  pc_gen_if.master        fetch,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            mret_i,
  input  logic            halt_i,
  input  logic            tvec_we_i,
  input  logic [XLEN-1:0] tvec_wdata_i,
  output logic [XLEN-1:0] epc_o,
  output logic [XLEN-1:0] tvec_o,
  output logic            misalign_o
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, epc_q, tvec_q;
  logic            misalign_q;
  logic [XLEN-1:0] pc_plus;
  logic [XLEN-1:0] pc_next, epc_next;
  logic            epc_load, misalign_next;
  logic            run_st, halt_st, seq_fire;
  src_t            src;

  assign run_st   = (state_q == ST_RUN);
  assign halt_st  = (state_q == ST_HALT);
  assign pc_plus  = pc_q + XLEN'(INC);
  assign seq_fire = run_st && fetch.imem_ready_i && !stall_i;

  assign fetch.imem_req_o = run_st;
  assign fetch.pc_o       = pc_q;
  assign fetch.pc_plus_o  = pc_plus;
  assign epc_o            = epc_q;
  assign tvec_o           = tvec_q;
  assign misalign_o       = misalign_q;

  pc_next_sel #(
    .XLEN      (XLEN),
    .ALIGN_BITS(ALIGN_BITS)
  ) u_sel (
    .run_st          (run_st),
    .halt_st         (halt_st),
    .trap_i          (trap_i),
    .trap_pc_i       (trap_pc_i),
    .mret_i          (mret_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .seq_fire        (seq_fire),
    .pc              (pc_q),
    .pc_plus         (pc_plus),
    .epc             (epc_q),
    .tvec            (tvec_q),
    .pc_next         (pc_next),
    .src             (src),
    .epc_load        (epc_load),
    .epc_next        (epc_next),
    .misalign_next   (misalign_next)
  );

  // Next-state logic; halt only takes effect when no redirect wins the cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (halt_i && !is_redirect(src)) state_d = ST_HALT;
      ST_HALT: if (trap_i || redirect_valid_i) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // State, PC and CSR-like registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      tvec_q     <= TVEC_RESET;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_next;
      misalign_q <= misalign_next;
      if (epc_load)  epc_q  <= epc_next;
      if (tvec_we_i) tvec_q <= tvec_wdata_i;
    end
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the fetch stage; successor to the basic single-register PC with stall.
- Adds configurable width, reset vector and instruction alignment.
- Adds prioritised redirect sources: trap, trap-return, branch/jump.
- Adds a trap-vector register, an exception-PC register, a halt (WFI) state and a valid/ready request handshake toward instruction memory.

Parameters:
XLEN, 32, PC/data width in bits
RESET_VECTOR, 32'h0000_0000, pc_o value on reset
TVEC_RESET, 32'h0000_0100, reset value of trap-vector register
ALIGN_BITS, 2, low PC bits that must be zero (2 = RV32I, 1 = compressed)
INC, 4, sequential increment in bytes

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
stall_i  in  1  hold sequential advance
redirect_valid_i  in  1  branch/jump taken
redirect_pc_i  in  XLEN  branch/jump target
trap_i  in  1  exception/interrupt request
trap_pc_i  in  XLEN  PC of the trapping instruction
mret_i  in  1  return from trap
halt_i  in  1  WFI: stop fetching
tvec_we_i  in  1  write trap-vector register
tvec_wdata_i  in  XLEN  trap-vector write data
imem_ready_i  in  1  instruction memory accepts current address
imem_req_o  out  1  fetch request valid
pc_o  out  XLEN  current fetch address
pc_plus_o  out  XLEN  pc_o + INC, combinational
epc_o  out  XLEN  saved exception PC
tvec_o  out  XLEN  trap-vector register
misalign_o  out  1  one-cycle pulse: misaligned redirect target

Behaviour:
- Reset (rst==0 at posedge, overrides everything):
  - pc_o=RESET_VECTOR, epc_o=0, tvec_o=TVEC_RESET, misalign_o=0, state=BOOT, imem_req_o=0.
- FSM states: BOOT, RUN, HALT.
  - BOOT->RUN unconditionally on the next clock after reset is released; pc_o unchanged.
  - RUN: imem_req_o=1.
  - RUN->HALT when halt_i=1 and no redirect source is active; pc_o <= pc_plus_o if the handshake also fires that cycle, else pc_o holds.
  - HALT: imem_req_o=0, pc_o holds. Exits to RUN only on trap_i or redirect_valid_i, with normal update; halt_i, stall_i and mret_i are ignored in HALT.
- pc_o next-value priority, evaluated at each posedge in RUN/HALT:
  1. trap_i: pc_o<=tvec_o with low ALIGN_BITS forced to 0; epc_o<=trap_pc_i.
  2. mret_i (RUN only): pc_o<=epc_o.
  3. redirect_valid_i:
     - Target aligned (redirect_pc_i[ALIGN_BITS-1:0]==0): pc_o<=redirect_pc_i.
     - Target misaligned: treated as a trap. pc_o<=tvec_o (aligned), epc_o<=redirect_pc_i, misalign_o=1 next cycle only.
  4. Sequential: pc_o<=pc_plus_o only when imem_req_o && imem_ready_i && !stall_i.
  5. Otherwise hold.
- Sources 1-3 override stall_i and pending handshakes (flush semantics). An un-accepted request for the old address is abandoned; imem_req_o stays 1 with the new address.
- tvec_we_i: tvec_o<=tvec_wdata_i next cycle.
  - Simultaneous trap_i uses the OLD tvec_o.
  - Allowed in any state except reset.
- Arithmetic: pc_plus_o = pc_o + INC modulo 2^XLEN; all-ones wraps to INC-1 region, no flag.
- Latency: every redirect is visible on pc_o exactly one cycle after its input is sampled.
- Reset asserted mid-operation (including HALT or a pending handshake) returns to BOOT in one cycle; no state is retained.

Decomposition:
- Shared package: XLEN default, RESET_VECTOR/TVEC_RESET defaults, FSM state enum type, redirect-source encoding enum (SRC_TRAP, SRC_MRET, SRC_BR, SRC_SEQ, SRC_HOLD).
- One natural sub-module, pc_next_sel: combinational priority mux producing the next-PC and source code. The registers and FSM stay in pc_gen.

Test Plan:
- Reset, then release; hold imem_ready_i=1 -> pc_o=0 in BOOT with req=0, then req=1, then pc_o 0x0, 0x4, 0x8 on successive cycles.
- stall_i=1 for 3 cycles at pc_o=0x8 -> pc_o stays 0x8; stall_i=1 together with redirect_valid_i to 0x40 -> pc_o=0x40 next cycle.
- imem_ready_i=0 for 2 cycles -> pc_o and req held; redirect to 0x80 arrives during the wait -> pc_o=0x80, req stays 1.
- trap_i with trap_pc_i=0x44, same cycle as redirect to 0x200 and mret_i -> pc_o=0x100, epc_o=0x44. Later mret_i -> pc_o=0x44.
- Redirect to 0x202 (ALIGN_BITS=2) -> pc_o=tvec_o, epc_o=0x202, misalign_o high for exactly one cycle.
- halt_i at pc_o=0x10 with ready=0 -> HALT, req=0, pc_o=0x10 held for 5 cycles despite mret_i. trap_i -> RUN at tvec_o. Separately, tvec_we_i 0x300 plus trap_i in the same cycle -> pc_o=0x100, then tvec_o=0x300.
